// File: rtl/mdu_ex_stage.sv
// EX-stage multiply/divide unit: owns HI/LO and holds busy for the
// modelled mult/div latency, committing results only when the count ends.
module mdu_ex_stage #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  MDUCtrl,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        intExcReq,
  output logic        busy,
  output logic [31:0] MDUResult,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ?
                        MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   hi_q, hi_d;
  logic [31:0]   lo_q, lo_d;
  logic [31:0]   ph_q, ph_d;
  logic [31:0]   pl_q, pl_d;

  logic is_mult, is_multu, is_div, is_divu;
  logic is_mthi, is_mtlo;

  assign is_mult  = (MDUCtrl == 4'd1);
  assign is_multu = (MDUCtrl == 4'd2);
  assign is_div   = (MDUCtrl == 4'd3);
  assign is_divu  = (MDUCtrl == 4'd4);
  assign is_mthi  = (MDUCtrl == 4'd7);
  assign is_mtlo  = (MDUCtrl == 4'd8);

  logic [63:0] prod_s, prod_u;

  assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
  assign prod_u = {32'd0, A} * {32'd0, B};

  // Signed divide via magnitudes, so MIN/-1 wraps cleanly to MIN
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, den;
  logic [31:0] q_mag, r_mag, quo, rem;

  assign a_neg = is_div & A[31];
  assign b_neg = is_div & B[31];
  assign a_mag = a_neg ? (~A + 32'd1) : A;
  assign b_mag = b_neg ? (~B + 32'd1) : B;
  assign den   = (B == 32'd0) ? 32'd1 : b_mag;
  assign q_mag = a_mag / den;
  assign r_mag = a_mag % den;
  assign quo   = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
  assign rem   = a_neg ? (~r_mag + 32'd1) : r_mag;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    ph_d    = ph_q;
    pl_d    = pl_q;
    case (state_q)
      IDLE: begin
        if (!intExcReq) begin
          unique case (1'b1)
            is_mult & start: begin
              ph_d    = prod_s[63:32];
              pl_d    = prod_s[31:0];
              cnt_d   = CW'(MULT_CYCLES);
              state_d = BUSY;
            end
            is_multu & start: begin
              ph_d    = prod_u[63:32];
              pl_d    = prod_u[31:0];
              cnt_d   = CW'(MULT_CYCLES);
              state_d = BUSY;
            end
            (is_div | is_divu) & start: begin
              ph_d    = (B == 32'd0) ? hi_q : rem;
              pl_d    = (B == 32'd0) ? lo_q : quo;
              cnt_d   = CW'(DIV_CYCLES);
              state_d = BUSY;
            end
            is_mthi: hi_d = A;
            is_mtlo: lo_d = A;
            default: ;
          endcase
        end
      end
      BUSY: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          hi_d    = ph_q;
          lo_d    = pl_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      ph_q    <= '0;
      pl_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      ph_q    <= ph_d;
      pl_q    <= pl_d;
    end
  end

  assign busy = (state_q == BUSY);
  assign HI   = hi_q;
  assign LO   = lo_q;

  always_comb begin
    MDUResult = 32'd0;
    if (MDUCtrl == 4'd5) MDUResult = hi_q;
    if (MDUCtrl == 4'd6) MDUResult = lo_q;
  end

endmodule

// File: tb/tb_mdu_ex_stage.sv
// Directed bench for mdu_ex_stage: vector table plus
// hand-written exception, reset and busy-ignore sequences.
module tb_mdu_ex_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  MDUCtrl;
  logic [31:0] A, B;
  logic        intExcReq;
  logic        busy;
  logic [31:0] MDUResult, HI, LO;

  int checks = 0;
  int errors = 0;

  mdu_ex_stage #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .MDUCtrl   (MDUCtrl),
    .A         (A),
    .B         (B),
    .intExcReq (intExcReq),
    .busy      (busy),
    .MDUResult (MDUResult),
    .HI        (HI),
    .LO        (LO)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } vec_t;

  vec_t vt[12];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    start     = 1'b0;
    MDUCtrl   = 4'd0;
    A         = 32'd0;
    B         = 32'd0;
    intExcReq = 1'b0;
  endtask

  // Count cycles busy is sampled high, bounded
  task automatic wait_idle(output int n);
    n = 0;
    while (busy === 1'b1 && n < 50) begin
      n++;
      tick();
    end
  endtask

  task automatic issue(input logic [3:0] c, input logic [31:0] a,
                       input logic [31:0] b);
    start   = 1'b1;
    MDUCtrl = c;
    A       = a;
    B       = b;
    tick();
    idle_in();
  endtask

  task automatic read_back(input string tag, input logic [31:0] eh,
                           input logic [31:0] el);
    MDUCtrl = 4'd5;
    #1;
    chk({tag, " mfhi"}, MDUResult, eh);
    MDUCtrl = 4'd6;
    #1;
    chk({tag, " mflo"}, MDUResult, el);
    MDUCtrl = 4'd0;
  endtask

  initial begin
    int n;
    vt[0]  = '{4'd7, 32'h0000_1234, 32'h0,
               32'h0000_1234, 32'h0000_0000, 0};
    vt[1]  = '{4'd8, 32'h0000_5678, 32'h0,
               32'h0000_1234, 32'h0000_5678, 0};
    vt[2]  = '{4'd3, 32'h0000_0005, 32'h0,
               32'h0000_1234, 32'h0000_5678, 10};
    vt[3]  = '{4'd1, 32'hFFFF_FFFF, 32'h2,
               32'hFFFF_FFFF, 32'hFFFF_FFFE, 5};
    vt[4]  = '{4'd2, 32'hFFFF_FFFF, 32'h2,
               32'h0000_0001, 32'hFFFF_FFFE, 5};
    vt[5]  = '{4'd3, 32'hFFFF_FFF9, 32'h2,
               32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
    vt[6]  = '{4'd4, 32'h0000_0007, 32'h2,
               32'h0000_0001, 32'h0000_0003, 10};
    vt[7]  = '{4'd3, 32'h8000_0000, 32'hFFFF_FFFF,
               32'h0000_0000, 32'h8000_0000, 10};
    vt[8]  = '{4'd1, 32'h0001_0000, 32'h0001_0000,
               32'h0000_0001, 32'h0000_0000, 5};
    vt[9]  = '{4'd4, 32'hFFFF_FFFF, 32'h10,
               32'h0000_000F, 32'h0FFF_FFFF, 10};
    vt[10] = '{4'd3, 32'h0000_0007, 32'hFFFF_FFFE,
               32'h0000_0001, 32'hFFFF_FFFD, 10};
    vt[11] = '{4'd1, 32'hFFFF_FFFD, 32'h5,
               32'hFFFF_FFFF, 32'hFFFF_FFF1, 5};

    idle_in();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset HI", HI, 32'd0);
    chk("reset LO", LO, 32'd0);
    chk("reset MDUResult", MDUResult, 32'd0);

    for (int i = 0; i < 12; i++) begin
      issue(vt[i].ctrl, vt[i].a, vt[i].b);
      wait_idle(n);
      chk($sformatf("v%0d busy cycles", i), n, vt[i].cyc);
      chk($sformatf("v%0d HI", i), HI, vt[i].hi);
      chk($sformatf("v%0d LO", i), LO, vt[i].lo);
      read_back($sformatf("v%0d", i), vt[i].hi, vt[i].lo);
    end

    // Known state: HI=0x1234, LO=0x5678
    issue(4'd7, 32'h1234, 32'h0);
    issue(4'd8, 32'h5678, 32'h0);

    intExcReq = 1'b1;
    issue(4'd1, 32'h3, 32'h4);
    chk("exc mult busy", {31'd0, busy}, 32'd0);
    tick();
    chk("exc mult HI", HI, 32'h1234);
    chk("exc mult LO", LO, 32'h5678);
    intExcReq = 1'b1;
    issue(4'd8, 32'hDEAD, 32'h0);
    chk("exc mtlo busy", {31'd0, busy}, 32'd0);
    chk("exc mtlo LO", LO, 32'h5678);

    // Exception while busy does not abort
    issue(4'd1, 32'h3, 32'h4);
    tick();
    intExcReq = 1'b1;
    tick();
    intExcReq = 1'b0;
    wait_idle(n);
    chk("late exc cycles", n + 2, 32'd5);
    chk("late exc HI", HI, 32'h0);
    chk("late exc LO", LO, 32'd12);

    // Ops presented while busy are ignored
    issue(4'd2, 32'h5, 32'h7);
    start   = 1'b1;
    MDUCtrl = 4'd7;
    A       = 32'hAAAA;
    tick();
    tick();
    tick();
    idle_in();
    wait_idle(n);
    chk("ignore cycles", n + 3, 32'd5);
    chk("ignore HI", HI, 32'h0);
    chk("ignore LO", LO, 32'd35);

    // Reset mid-divide aborts with no late commit
    issue(4'd7, 32'h9999, 32'h0);
    issue(4'd4, 32'd100, 32'd7);
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort busy", {31'd0, busy}, 32'd0);
    chk("abort HI", HI, 32'd0);
    chk("abort LO", LO, 32'd0);
    for (int k = 0; k < 12; k++) tick();
    chk("abort late HI", HI, 32'd0);
    chk("abort late LO", LO, 32'd0);
    chk("abort late busy", {31'd0, busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
